// File: rtl/network_div_pkg.sv
// Shared widths, FSM state type and saturation limits for the network divider.
package network_div_pkg;

   localparam int unsigned DIVIDEND_W_DEF = 27;
   localparam int unsigned DIVISOR_W_DEF  = 11;
   localparam int unsigned QUOT_W_DEF     = 16;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   localparam logic [QUOT_W_DEF-1:0] QMAX = 16'h7fff;
   localparam logic [QUOT_W_DEF-1:0] QMIN = 16'h8000;

endpackage

// File: rtl/network_div_step.sv
// One radix-2 restoring iteration on magnitudes: shift the next dividend bit
// into the partial remainder, subtract the divisor if it fits, emit one quotient bit.
module network_div_step
   import network_div_pkg::*;
#(
   parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
   input  logic [DIVISOR_W:0]    rem_in,
   input  logic [DIVIDEND_W-1:0] quot_in,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic [DIVISOR_W:0]    rem_out,
   output logic [DIVIDEND_W-1:0] quot_out
);

   localparam int unsigned REM_W = DIVISOR_W + 1;

   logic [REM_W:0] shifted;
   logic [REM_W:0] diff;
   logic           fits;

   // The remainder stays below the divisor magnitude, so the top bit of diff is a clean borrow.
   assign shifted  = {rem_in, quot_in[DIVIDEND_W-1]};
   assign diff     = shifted - (REM_W+1)'(divisor);
   assign fits     = ~diff[REM_W];
   assign rem_out  = fits ? diff[REM_W-1:0] : shifted[REM_W-1:0];
   assign quot_out = {quot_in[DIVIDEND_W-2:0], fits};

endmodule

// File: rtl/network_div_seq_27s_11s_16.sv
// Iterative signed divider 27s / 11s -> saturated 16s, one quotient bit per enabled cycle.
// Optional remainder output guarded by NETWORK_DIV_REM_EN.
module network_div_seq_27s_11s_16
   import network_div_pkg::*;
#(
   parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF,
   parameter int unsigned QUOT_W     = QUOT_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] din0,
   input  logic [DIVISOR_W-1:0]  din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [QUOT_W-1:0]     dout,
   output logic                  ovf,
   output logic                  dbz
`ifdef NETWORK_DIV_REM_EN
   ,
   output logic [DIVISOR_W-1:0]  rem
`endif
);

   localparam int unsigned REM_W = DIVISOR_W + 1;
   localparam int unsigned CNT_W = $clog2(DIVIDEND_W);

   localparam logic [QUOT_W-1:0]     q_max   = {1'b0, {(QUOT_W-1){1'b1}}};
   localparam logic [QUOT_W-1:0]     q_min   = {1'b1, {(QUOT_W-1){1'b0}}};
   localparam logic [DIVIDEND_W-1:0] pos_lim = DIVIDEND_W'(q_max);
   localparam logic [DIVIDEND_W-1:0] neg_lim = DIVIDEND_W'(q_min);
   localparam logic [CNT_W-1:0]      last    = CNT_W'(DIVIDEND_W - 1);

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic [REM_W-1:0]      rem_q;
   logic [DIVIDEND_W-1:0] quot_q;
   logic [DIVISOR_W-1:0]  div_q;
   logic                  sign_q;
   logic                  sign_d;
   logic                  dbz_l;

   logic [DIVIDEND_W-1:0] din0_mag;
   logic [DIVISOR_W-1:0]  din1_mag;
   logic [REM_W-1:0]      rem_nxt;
   logic [DIVIDEND_W-1:0] quot_nxt;

   // Magnitudes fit unsigned in the operand width, including the most negative value.
   assign din0_mag = din0[DIVIDEND_W-1] ? DIVIDEND_W'(0) - din0 : din0;
   assign din1_mag = din1[DIVISOR_W-1]  ? DIVISOR_W'(0) - din1  : din1;

   network_div_step #(
      .DIVIDEND_W (DIVIDEND_W),
      .DIVISOR_W  (DIVISOR_W)
   ) u_step (
      .rem_in   (rem_q),
      .quot_in  (quot_q),
      .divisor  (div_q),
      .rem_out  (rem_nxt),
      .quot_out (quot_nxt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         dout      <= '0;
         ovf       <= 1'b0;
         dbz       <= 1'b0;
         rem_q     <= '0;
         quot_q    <= '0;
         div_q     <= '0;
         sign_q    <= 1'b0;
         sign_d    <= 1'b0;
         dbz_l     <= 1'b0;
`ifdef NETWORK_DIV_REM_EN
         rem       <= '0;
`endif
      end else if (ce) begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  quot_q   <= din0_mag;
                  rem_q    <= '0;
                  div_q    <= din1_mag;
                  sign_q   <= din0[DIVIDEND_W-1] ^ din1[DIVISOR_W-1];
                  sign_d   <= din0[DIVIDEND_W-1];
                  dbz_l    <= (din1 == '0);
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= CALC;
               end
            end
            CALC: begin
               rem_q  <= rem_nxt;
               quot_q <= quot_nxt;
               if (cnt == last) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            FIX: begin
               // Sign application and saturation; a zero divisor forces the rail of the dividend's sign.
               if (dbz_l) begin
                  dout <= sign_d ? q_min : q_max;
                  ovf  <= 1'b1;
               end else if (!sign_q) begin
                  ovf  <= (quot_q > pos_lim);
                  dout <= (quot_q > pos_lim) ? q_max : quot_q[QUOT_W-1:0];
               end else begin
                  ovf  <= (quot_q > neg_lim);
                  dout <= (quot_q > neg_lim) ? q_min : QUOT_W'(0) - quot_q[QUOT_W-1:0];
               end
               dbz <= dbz_l;
`ifdef NETWORK_DIV_REM_EN
               if (dbz_l) begin
                  rem <= '0;
               end else begin
                  rem <= sign_d ? DIVISOR_W'(0) - rem_q[DIVISOR_W-1:0] : rem_q[DIVISOR_W-1:0];
               end
`endif
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_network_div_seq_27s_11s_16.sv
// Self-checking bench for network_div_seq_27s_11s_16; covers NETWORK_DIV_REM_EN when defined.
module tb_network_div_seq_27s_11s_16;

   logic        clk = 1'b0;
   logic        reset;
   logic        ce;
   logic        in_valid;
   logic        in_ready;
   logic [26:0] din0;
   logic [10:0] din1;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] dout;
   logic        ovf;
   logic        dbz;
`ifdef NETWORK_DIV_REM_EN
   logic [10:0] rem;
`endif

   int n_cmp = 0;
   int n_err = 0;

   network_div_seq_27s_11s_16 dut (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din0      (din0),
      .din1      (din1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .ovf       (ovf),
      .dbz       (dbz)
`ifdef NETWORK_DIV_REM_EN
      ,
      .rem       (rem)
`endif
   );

   always #5 clk = ~clk;

   // Reference: integer division truncating toward zero, then clamp to 16-bit signed.
   function automatic void model(input int d, input int v, output logic [15:0] q,
                                 output logic o, output logic z, output logic [10:0] r);
      int qt;
      if (v == 0) begin
         q = (d >= 0) ? 16'h7fff : 16'h8000;
         o = 1'b1;
         z = 1'b1;
         r = '0;
      end else begin
         qt = d / v;
         r  = 11'(d % v);
         z  = 1'b0;
         if (qt > 32767) begin
            q = 16'h7fff;
            o = 1'b1;
         end else if (qt < -32768) begin
            q = 16'h8000;
            o = 1'b1;
         end else begin
            q = 16'(qt);
            o = 1'b0;
         end
      end
   endfunction

   // Presents one operand pair, then counts ce-high edges until out_valid (result left pending).
   task automatic do_op(input int d, input int v, input int ce_lows, output int edges, output bit tmo);
      int lows;
      bit cur;
      lows     = ce_lows;
      tmo      = 1'b0;
      edges    = 0;
      ce       = 1'b1;
      din0     = 27'(d);
      din1     = 11'(v);
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !in_ready; i++) begin
         @(posedge clk); #1;
      end
      if (!in_ready) tmo = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      din0     = 27'($urandom());
      din1     = 11'($urandom());
      for (int i = 0; i < 200; i++) begin
         if (lows > 0 && edges >= 3 && $urandom_range(0, 1) == 1) begin
            ce = 1'b0;
            lows--;
         end else begin
            ce = 1'b1;
         end
         cur = ce;
         @(posedge clk); #1;
         if (cur) edges++;
         if (out_valid) break;
      end
      ce = 1'b1;
      if (!out_valid) tmo = 1'b1;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      ce        = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (dout !== 16'h0) begin n_err++; $display("FAIL reset_dout got %h want 0000", dout); end
      n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
      n_cmp++; if (dbz !== 1'b0) begin n_err++; $display("FAIL reset_dbz got %b want 0", dbz); end
`ifdef NETWORK_DIV_REM_EN
      n_cmp++; if (rem !== 11'h0) begin n_err++; $display("FAIL reset_rem got %h want 000", rem); end
`endif
   endtask

   task automatic test_directed();
      int          td[10] = '{1000, -1000, 1000, 67108863, -32768, -67108864, 5, -5, -1000, 0};
      int          tv[10] = '{7, 7, -7, 1, 1, -1, 0, 0, -7, 0};
      int          tq[10] = '{142, -142, -142, 32767, -32768, 32767, 32767, -32768, 142, 32767};
      bit          to[10] = '{0, 0, 0, 1, 0, 1, 1, 1, 0, 1};
      bit          tz[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1};
      int          tr[10] = '{6, -6, 6, 0, 0, 0, 0, 0, -6, 0};
      int          edges;
      bit          tmo;
      logic [15:0] eq;
      logic [10:0] er;
      for (int i = 0; i < 10; i++) begin
         do_op(td[i], tv[i], 0, edges, tmo);
         eq = 16'(tq[i]);
         er = 11'(tr[i]);
         n_cmp++; if (tmo || edges != 28) begin n_err++; $display("FAIL dir%0d_latency got %0d timeout %0d want 28", i, edges, tmo); end
         n_cmp++; if (dout !== eq) begin n_err++; $display("FAIL dir%0d_dout got %0d want %0d", i, $signed(dout), $signed(eq)); end
         n_cmp++; if (ovf !== to[i]) begin n_err++; $display("FAIL dir%0d_ovf got %b want %b", i, ovf, to[i]); end
         n_cmp++; if (dbz !== tz[i]) begin n_err++; $display("FAIL dir%0d_dbz got %b want %b", i, dbz, tz[i]); end
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL dir%0d_in_ready_done got %b want 0", i, in_ready); end
`ifdef NETWORK_DIV_REM_EN
         n_cmp++; if (rem !== er) begin n_err++; $display("FAIL dir%0d_rem got %0d want %0d", i, $signed(rem), $signed(er)); end
`endif
         consume();
         n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL dir%0d_release got ov=%b ir=%b want ov=0 ir=1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_ce_stall();
      int          d, v, edges;
      bit          tmo;
      logic [15:0] eq;
      logic        eo, ez;
      logic [10:0] er;
      // A disabled cycle in IDLE must not accept.
      ce       = 1'b0;
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL ce_idle got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
      end
      for (int k = 0; k < 3; k++) begin
         d = int'($urandom_range(0, 200000)) - 100000;
         v = int'($urandom_range(1, 40)) * ((k == 1) ? -1 : 1);
         model(d, v, eq, eo, ez, er);
         do_op(d, v, 10, edges, tmo);
         n_cmp++; if (tmo || edges != 28) begin n_err++; $display("FAIL stall%0d_latency got %0d timeout %0d want 28", k, edges, tmo); end
         n_cmp++; if (dout !== eq || ovf !== eo || dbz !== ez) begin
            n_err++; $display("FAIL stall%0d_result got %0d/%b/%b want %0d/%b/%b", k, $signed(dout), ovf, dbz, $signed(eq), eo, ez);
         end
`ifdef NETWORK_DIV_REM_EN
         n_cmp++; if (rem !== er) begin n_err++; $display("FAIL stall%0d_rem got %0d want %0d", k, $signed(rem), $signed(er)); end
`endif
         consume();
      end
   endtask

   task automatic test_hold();
      int          edges;
      bit          tmo;
      logic [15:0] eq;
      logic        eo, ez;
      logic [10:0] er;
      model(-123456, 37, eq, eo, ez, er);
      do_op(-123456, 37, 0, edges, tmo);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_cmp++; if (dout !== eq || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL hold%0d got dout=%0d ov=%b ir=%b want dout=%0d ov=1 ir=0", i, $signed(dout), out_valid, in_ready, $signed(eq));
         end
      end
      ce        = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_ce_low_consume got ov=%b want 1", out_valid); end
      consume();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release got ov=%b want 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      int  edges;
      bit  tmo;
      bit  seen;
      ce       = 1'b1;
      din0     = 27'(77777);
      din1     = 11'(3);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL mid_reset got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
      end
      seen = 1'b0;
      for (int i = 0; i < 35; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_reset_no_result got out_valid seen=%b want 0", seen); end
      do_op(90, 9, 0, edges, tmo);
      n_cmp++; if (tmo || edges != 28 || dout !== 16'd10 || ovf !== 1'b0) begin
         n_err++; $display("FAIL mid_reset_next got %0d ovf=%b edges=%0d want 10 ovf=0 edges=28", $signed(dout), ovf, edges);
      end
      consume();
   endtask

   task automatic test_random();
      int          d, v, edges;
      bit          tmo;
      logic [26:0] t;
      logic [15:0] eq;
      logic        eo, ez;
      logic [10:0] er;
      for (int k = 0; k < 25; k++) begin
         case ($urandom_range(0, 3))
            0: begin t = 27'($urandom()); d = int'($signed(t)); end
            1: d = int'($urandom_range(0, 2000000)) - 1000000;
            default: d = int'($urandom_range(0, 80000)) - 40000;
         endcase
         case ($urandom_range(0, 7))
            0: v = 0;
            1, 2: v = int'($urandom_range(0, 40)) - 20;
            default: begin t = 27'($urandom()); v = int'($signed(t[10:0])); end
         endcase
         model(d, v, eq, eo, ez, er);
         do_op(d, v, int'($urandom_range(0, 4)), edges, tmo);
         n_cmp++; if (tmo || edges != 28 || dout !== eq || ovf !== eo || dbz !== ez) begin
            n_err++;
            $display("FAIL rand%0d %0d/%0d got %0d/%b/%b edges %0d want %0d/%b/%b", k, d, v, $signed(dout), ovf, dbz, edges, $signed(eq), eo, ez);
         end
`ifdef NETWORK_DIV_REM_EN
         n_cmp++; if (rem !== er) begin n_err++; $display("FAIL rand%0d_rem got %0d want %0d", k, $signed(rem), $signed(er)); end
`endif
         consume();
      end
   endtask

   initial begin
      reset     = 1'b1;
      ce        = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      din0      = '0;
      din1      = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_directed();
      test_ce_stall();
      test_hold();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
